// File: rtl/painterengine_gpu_dma_reader_pkg.sv
// Shared constants for the GPU DMA reader: FSM state encodings and AXI4 field values.
// Combinational only; no backpressure.
package painterengine_gpu_dma_reader_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CALC  = 3'd1;
    localparam logic [2:0] ST_ADDR  = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ERROR = 3'd5;
    localparam logic [2:0] ST_DRAIN = 3'd6;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/painterengine_gpu_burst_calc.sv
// Burst sizing: beats = min(remaining, MAX_BURST, words left in the 4 KB page).
// Purely combinational, zero latency; no backpressure.
module painterengine_gpu_burst_calc #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic [31:0] remaining_i,
    input  logic [9:0]  word_off_i,
    output logic [8:0]  beats_o,
    output logic [7:0]  arlen_o
);
    localparam logic [31:0] MAX_B32 = 32'(MAX_BURST);

    logic [10:0] room_words;
    logic [8:0]  rem_cap;

    // Page room in words: 1024 at a page start, down to 1 at the last word.
    assign room_words = 11'd1024 - {1'b0, word_off_i};
    assign rem_cap    = (remaining_i > MAX_B32) ? MAX_B32[8:0] : remaining_i[8:0];
    assign beats_o    = (room_words < {2'b00, rem_cap}) ? room_words[8:0] : rem_cap;
    assign arlen_o    = beats_o[7:0] - 8'd1;

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// AXI4 read master: splits a word job into INCR bursts and forwards R beats to the pixel FIFO.
// Data path 0 latency (rdata passes straight through); rready follows i_wire_data_next.
module painterengine_gpu_dma_reader
    import painterengine_gpu_dma_reader_pkg::*;
#(
    parameter int unsigned MAX_BURST      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        i_wire_clock,
    input  logic        i_wire_reset,
    input  logic        i_wire_enable,
    input  logic [31:0] i_wire_address,
    input  logic [31:0] i_wire_length,
    output logic        o_wire_done,
    output logic        o_wire_error,
    output logic [31:0] o_wire_data,
    output logic        o_wire_data_valid,
    input  logic        i_wire_data_next,
    output logic [31:0] o_wire_m_axi_araddr,
    output logic [7:0]  o_wire_m_axi_arlen,
    output logic [2:0]  o_wire_m_axi_arsize,
    output logic [1:0]  o_wire_m_axi_arburst,
    output logic        o_wire_m_axi_arvalid,
    input  logic        i_wire_m_axi_arready,
    input  logic [31:0] i_wire_m_axi_rdata,
    input  logic [1:0]  i_wire_m_axi_rresp,
    input  logic        i_wire_m_axi_rlast,
    input  logic        i_wire_m_axi_rvalid,
    output logic        o_wire_m_axi_rready
);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic [29:0] waddr_q, waddr_d, araddr_q, araddr_d;
    logic [31:0] remaining_q, remaining_d, tmo_q, tmo_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [8:0]  beats_q, beats_d, beat_cnt_q, beat_cnt_d;
    logic        err_q, err_d, abort_q, abort_d;

    logic [8:0]  calc_beats;
    logic [7:0]  calc_arlen;
    logic        ar_hs, r_hs, resp_ok, last_exp, beat_err, burst_end, tmo_hit;

    painterengine_gpu_burst_calc #(.MAX_BURST(MAX_BURST)) u_burst_calc (
        .remaining_i (remaining_q),
        .word_off_i  (waddr_q[9:0]),
        .beats_o     (calc_beats),
        .arlen_o     (calc_arlen)
    );

    assign o_wire_m_axi_arvalid = (state_q == ST_ADDR);
    // Once a bad response is seen the rest of the burst is swallowed regardless of the consumer.
    assign o_wire_m_axi_rready  = (state_q == ST_DATA)  ? (err_q | i_wire_data_next)
                                                        : (state_q == ST_DRAIN);
    assign ar_hs     = o_wire_m_axi_arvalid & i_wire_m_axi_arready;
    assign r_hs      = o_wire_m_axi_rready & i_wire_m_axi_rvalid;
    assign resp_ok   = (i_wire_m_axi_rresp == AXI_RESP_OKAY);
    assign last_exp  = ((beat_cnt_q + 9'd1) == beats_q);
    assign beat_err  = !resp_ok | (i_wire_m_axi_rlast != last_exp);
    assign burst_end = i_wire_m_axi_rlast | last_exp;
    assign tmo_hit   = (tmo_q == TMO_LAST) & !ar_hs & !r_hs;

    assign o_wire_data_valid    = (state_q == ST_DATA) & r_hs & resp_ok & !err_q;
    assign o_wire_data          = i_wire_m_axi_rdata;
    assign o_wire_done          = (state_q == ST_DONE);
    assign o_wire_error         = (state_q == ST_ERROR);
    assign o_wire_m_axi_araddr  = {araddr_q, 2'b00};
    assign o_wire_m_axi_arlen   = arlen_q;
    assign o_wire_m_axi_arsize  = AXI_SIZE_4B;
    assign o_wire_m_axi_arburst = AXI_BURST_INCR;

    always_comb begin
        state_d     = state_q;
        waddr_d     = waddr_q;
        araddr_d    = araddr_q;
        remaining_d = remaining_q;
        arlen_d     = arlen_q;
        beats_d     = beats_q;
        beat_cnt_d  = beat_cnt_q;
        err_d       = err_q;
        abort_d     = abort_q;
        tmo_d       = 32'd0;

        if ((state_q == ST_ADDR || state_q == ST_DATA || state_q == ST_DRAIN) && !ar_hs && !r_hs)
            tmo_d = tmo_q + 32'd1;

        case (state_q)
            ST_IDLE: if (i_wire_enable) begin
                waddr_d     = i_wire_address[31:2];
                remaining_d = i_wire_length;
                err_d       = 1'b0;
                abort_d     = 1'b0;
                if (i_wire_address[1:0] != 2'b00) state_d = ST_ERROR;
                else if (i_wire_length == 32'd0)  state_d = ST_DONE;
                else                              state_d = ST_CALC;
            end
            ST_CALC: if (!i_wire_enable) begin
                state_d = ST_IDLE;
            end else begin
                araddr_d   = waddr_q;
                arlen_d    = calc_arlen;
                beats_d    = calc_beats;
                beat_cnt_d = 9'd0;
                state_d    = ST_ADDR;
            end
            ST_ADDR: begin
                // An abort cannot withdraw arvalid; remember it and drain after the handshake.
                if (!i_wire_enable) abort_d = 1'b1;
                if (ar_hs)        state_d = (abort_q | !i_wire_enable) ? ST_DRAIN : ST_DATA;
                else if (tmo_hit) state_d = ST_ERROR;
            end
            ST_DATA: begin
                if (r_hs) begin
                    beat_cnt_d  = beat_cnt_q + 9'd1;
                    remaining_d = remaining_q - 32'd1;
                    waddr_d     = waddr_q + 30'd1;
                    if (beat_err) err_d = 1'b1;
                    if (burst_end) begin
                        if (!i_wire_enable)             state_d = ST_IDLE;
                        else if (err_q | beat_err)      state_d = ST_ERROR;
                        else if (remaining_q == 32'd1)  state_d = ST_DONE;
                        else                            state_d = ST_CALC;
                    end else if (!i_wire_enable) begin
                        state_d = ST_DRAIN;
                    end
                end else if (!i_wire_enable) begin
                    state_d = ST_DRAIN;
                end else if (tmo_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DRAIN: begin
                if (r_hs && i_wire_m_axi_rlast) state_d = ST_IDLE;
                else if (tmo_hit)               state_d = ST_ERROR;
            end
            ST_DONE, ST_ERROR: if (!i_wire_enable) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            state_q     <= ST_IDLE;
            waddr_q     <= '0;
            araddr_q    <= '0;
            remaining_q <= '0;
            arlen_q     <= '0;
            beats_q     <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            abort_q     <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            waddr_q     <= waddr_d;
            araddr_q    <= araddr_d;
            remaining_q <= remaining_d;
            arlen_q     <= arlen_d;
            beats_q     <= beats_d;
            beat_cnt_q  <= beat_cnt_d;
            err_q       <= err_d;
            abort_q     <= abort_d;
            tmo_q       <= tmo_d;
        end
    end

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for the GPU DMA reader: randomized AXI slave and consumer, job-level reference model.
module tb_painterengine_gpu_dma_reader;

    logic        clk = 1'b0;
    logic        rst, en, done, err, dv, dn;
    logic [31:0] addr_in, len_in, dat;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst, rresp;
    logic        arvalid, arready, rlast, rvalid, rready;

    always #5 clk = ~clk;

    painterengine_gpu_dma_reader #(.MAX_BURST(16), .TIMEOUT_CYCLES(4096)) dut (
        .i_wire_clock(clk), .i_wire_reset(rst), .i_wire_enable(en),
        .i_wire_address(addr_in), .i_wire_length(len_in),
        .o_wire_done(done), .o_wire_error(err),
        .o_wire_data(dat), .o_wire_data_valid(dv), .i_wire_data_next(dn),
        .o_wire_m_axi_araddr(araddr), .o_wire_m_axi_arlen(arlen),
        .o_wire_m_axi_arsize(arsize), .o_wire_m_axi_arburst(arburst),
        .o_wire_m_axi_arvalid(arvalid), .i_wire_m_axi_arready(arready),
        .i_wire_m_axi_rdata(rdata), .i_wire_m_axi_rresp(rresp),
        .i_wire_m_axi_rlast(rlast), .i_wire_m_axi_rvalid(rvalid),
        .o_wire_m_axi_rready(rready)
    );

    int checks = 0;
    int errors = 0;

    // Slave / consumer knobs and logs
    int          p_arready = 100, p_rvalid = 100, p_dn = 100;
    bit          dn_toggle = 0, stall = 0, strict_rr = 0;
    int          hold_at = 0;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    logic        slv_act = 1'b0;
    logic [31:0] slv_addr = 0;
    int          slv_beat = 0, slv_len = 0, r_cnt = 0, viol = 0;
    logic [31:0] ar_log_a[$];
    int          ar_log_l[$];
    logic [31:0] got[$];
    logic [31:0] exp_a[$];
    int          exp_l[$];
    logic [31:0] exp_d[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // AXI read slave + FIFO consumer: sample at negedge, drive 1 ns after posedge.
    initial begin
        arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0; dn = 0;
        forever begin
            bit ar_hs, r_hs;
            logic [31:0] a;
            @(negedge clk);
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (dv) got.push_back(dat);
            if (dv && !dn) viol++;
            if (strict_rr && rready && !dn) viol++;
            @(posedge clk); #1;
            if (rst) begin
                slv_act = 1'b0;
                rvalid  = 1'b0;
            end else begin
                if (r_hs) begin
                    r_cnt++;
                    slv_beat++;
                    if (slv_beat == slv_len) slv_act = 1'b0;
                end
                if (ar_hs) begin
                    ar_log_a.push_back(araddr);
                    ar_log_l.push_back(int'(arlen) + 1);
                    slv_act = 1'b1; slv_addr = araddr; slv_beat = 0; slv_len = int'(arlen) + 1;
                end
                if (!slv_act) rvalid = 1'b0;
                else if (!rvalid || r_hs) rvalid = !stall && ($urandom % 100 < p_rvalid);
            end
            a     = slv_addr + 32'(4 * slv_beat);
            rdata = mem_word(a);
            rresp = (a == err_addr) ? 2'b10 : 2'b00;
            rlast = (slv_beat == slv_len - 1);
            arready = !slv_act && ($urandom % 100 < p_arready);
            if (hold_at > 0 && got.size() >= hold_at) dn = 1'b0;
            else if (dn_toggle) dn = !dn;
            else dn = ($urandom % 100 < p_dn);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic clear_logs;
        ar_log_a.delete(); ar_log_l.delete(); got.delete();
        viol = 0; r_cnt = 0;
    endtask

    // Reference: page-bounded 16-beat bursts and address-ordered data.
    task automatic model(input logic [31:0] a0, input int len);
        logic [31:0] a;
        int rem, room, b;
        exp_a.delete(); exp_l.delete(); exp_d.delete();
        a = a0; rem = len;
        while (rem > 0) begin
            room = (4096 - int'(a & 32'hFFF)) / 4;
            b = rem;
            if (b > 16) b = 16;
            if (b > room) b = room;
            exp_a.push_back(a); exp_l.push_back(b);
            a += 32'(4 * b); rem -= b;
        end
        for (int i = 0; i < len; i++) exp_d.push_back(mem_word(a0 + 32'(4 * i)));
    endtask

    task automatic wait_end(input int budget, output bit ok, output int n);
        ok = 0; n = 0;
        while (n < budget) begin
            @(posedge clk); #1; n++;
            if (done || err) begin ok = 1; break; end
        end
    endtask

    task automatic cmp_logs(input string tag);
        check({tag, "_ar_cnt"}, ar_log_a.size(), exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            check({tag, "_araddr"}, (i < ar_log_a.size()) ? ar_log_a[i] : 32'h0BAD_0BAD, exp_a[i]);
            check({tag, "_arlen"},  (i < ar_log_l.size()) ? ar_log_l[i] : -1, exp_l[i]);
        end
        check({tag, "_beats"}, got.size(), exp_d.size());
        for (int i = 0; i < exp_d.size(); i++)
            check({tag, "_data"}, (i < got.size()) ? got[i] : ~exp_d[i], exp_d[i]);
    endtask

    task automatic run_job(input string tag, input logic [31:0] a, input int len);
        bit ok;
        int n;
        clear_logs();
        model(a, len);
        strict_rr = 1;
        addr_in = a; len_in = 32'(len); en = 1;
        wait_end(4000, ok, n);
        check({tag, "_finished"}, ok, 1);
        check({tag, "_done"}, done, 1);
        check({tag, "_error"}, err, 0);
        cmp_logs(tag);
        check({tag, "_flow"}, viol, 0);
        en = 0;
        cyc(2);
        check({tag, "_done_clr"}, done, 0);
        strict_rr = 0;
    endtask

    initial begin
        bit ok;
        int n;
        rst = 1; en = 0; addr_in = 0; len_in = 0;
        cyc(3);
        check("rst_done", done, 0);
        check("rst_error", err, 0);
        check("rst_arvalid", arvalid, 0);
        check("rst_rready", rready, 0);
        check("rst_dv", dv, 0);
        check("rst_araddr", araddr, 0);
        check("arsize", arsize, 3'b010);
        check("arburst", arburst, 2'b01);
        rst = 0;
        cyc(2);
        check("idle_arvalid", arvalid, 0);

        run_job("t1", 32'h1000_0000, 32);
        run_job("t2", 32'h0000_0FF0, 8);
        dn_toggle = 1;
        run_job("t3", 32'h1000_0100, 32);
        dn_toggle = 0;

        for (int k = 0; k < 8; k++) begin
            logic [31:0] a;
            a = ($urandom & 32'h7FFF_F000) | 32'(4096 - 4 * $urandom_range(1, 48));
            p_arready = $urandom_range(30, 100);
            p_rvalid  = $urandom_range(30, 100);
            p_dn      = $urandom_range(30, 100);
            run_job("rnd", a, $urandom_range(1, 60));
        end
        p_arready = 100; p_rvalid = 100; p_dn = 100;

        // Slave error on the fifth beat of a single burst.
        clear_logs();
        err_addr = 32'h2000_0010;
        addr_in = 32'h2000_0000; len_in = 16; en = 1;
        wait_end(2000, ok, n);
        check("slverr_finished", ok, 1);
        check("slverr_error", err, 1);
        check("slverr_done", done, 0);
        cyc(20);
        check("slverr_ar_cnt", ar_log_a.size(), 1);
        check("slverr_drained", r_cnt, 16);
        check("slverr_fwd", got.size(), 4);
        for (int i = 0; i < 4; i++)
            check("slverr_data", (i < got.size()) ? got[i] : 32'h0, mem_word(32'h2000_0000 + 32'(4 * i)));
        check("slverr_held", err, 1);
        en = 0; err_addr = 32'hFFFF_FFFF;
        cyc(2);
        check("slverr_clr", err, 0);

        // Abort after four forwarded beats.
        clear_logs();
        hold_at = 4;
        addr_in = 32'h3000_0000; len_in = 16; en = 1;
        n = 0;
        while (n < 500) begin
            @(posedge clk); #2; n++;
            if (got.size() >= 4) break;
        end
        en = 0;
        n = 0;
        while (n < 500 && (slv_act || r_cnt < 16)) begin @(posedge clk); #2; n++; end
        cyc(2);
        check("abort_drained", r_cnt, 16);
        check("abort_fwd", got.size(), 4);
        check("abort_ar_cnt", ar_log_a.size(), 1);
        check("abort_done", done, 0);
        check("abort_error", err, 0);
        hold_at = 0;
        run_job("reen", 32'h3000_0400, 4);

        // Zero length and misaligned address never issue AR.
        clear_logs();
        addr_in = 32'h4000_0000; len_in = 0; en = 1;
        wait_end(50, ok, n);
        check("len0_done", done, 1);
        check("len0_error", err, 0);
        cyc(5);
        check("len0_ar", ar_log_a.size(), 0);
        en = 0; cyc(2);
        addr_in = 32'h0000_0002; len_in = 4; en = 1;
        wait_end(50, ok, n);
        check("unal_error", err, 1);
        check("unal_done", done, 0);
        cyc(5);
        check("unal_ar", ar_log_a.size(), 0);
        en = 0; cyc(2);

        // Stalled R channel times out.
        clear_logs();
        stall = 1;
        addr_in = 32'h5000_0000; len_in = 8; en = 1;
        wait_end(6000, ok, n);
        check("tmo_finished", ok, 1);
        check("tmo_error", err, 1);
        check("tmo_done", done, 0);
        check("tmo_late", (n >= 4090) ? 1 : 0, 1);
        check("tmo_arvalid", arvalid, 0);
        check("tmo_rready", rready, 0);
        en = 0; stall = 0;
        cyc(2);
        rst = 1; cyc(2); rst = 0; cyc(2);

        // Asynchronous reset in the middle of a burst.
        clear_logs();
        addr_in = 32'h6000_0000; len_in = 32; en = 1;
        n = 0;
        while (n < 500) begin
            @(posedge clk); #2; n++;
            if (got.size() >= 3) break;
        end
        check("mid_rready_pre", rready, 1);
        rst = 1; #1;
        check("mid_arvalid", arvalid, 0);
        check("mid_rready", rready, 0);
        check("mid_dv", dv, 0);
        check("mid_done", done, 0);
        check("mid_error", err, 0);
        en = 0;
        cyc(2);
        rst = 0;
        cyc(2);
        check("post_rst_done", done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
